// File: rtl/framebuffer_scanout.sv
// Cell-based 12-bit framebuffer with 2-cycle scanout and a game-logic write port.
// Define FB_CLEAR_ENGINE_EN to build in the whole-buffer fill engine.
module framebuffer_scanout #(
  parameter int unsigned FB_W        = 200,
  parameter int unsigned FB_H        = 150,
  parameter int unsigned SCALE_SHIFT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_x,
  input  logic [7:0]  wr_y,
  input  logic [11:0] wr_color,
  input  logic        clear_req,
  input  logic [11:0] clear_color,
  output logic        clear_busy,
  output logic [3:0]  out_r,
  output logic [3:0]  out_g,
  output logic [3:0]  out_b
);

  localparam int unsigned Depth = FB_W * FB_H;
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  // y*FB_W + x as a sum of shifted rows, one term per set bit of FB_W.
  function automatic logic [AddrW-1:0] cell_addr(input logic [9:0] y, input logic [9:0] x);
    logic [AddrW-1:0] acc;
    acc = AddrW'(x);
    for (int unsigned i = 0; i < AddrW; i++) begin
      if (FB_W[i]) begin
        acc = acc + (AddrW'(y) << i);
      end
    end
    return acc;
  endfunction

  // Read side: pixel to cell mapping and blank detection
  logic [9:0]       cell_x, cell_y;
  logic             rd_blank;
  logic [AddrW-1:0] rd_addr;

  assign cell_x   = pixel_x >> SCALE_SHIFT;
  assign cell_y   = pixel_y >> SCALE_SHIFT;
  assign rd_blank = (pixel_x == 10'h3FF) || (pixel_y == 10'h3FF) ||
                    (32'(cell_x) >= FB_W) || (32'(cell_y) >= FB_H);
  assign rd_addr  = rd_blank ? '0 : cell_addr(cell_y, cell_x);

  // Write side
  logic             wr_in_range, host_we;
  logic [AddrW-1:0] wr_addr;
  logic             fill_we;
  logic [AddrW-1:0] fill_addr;
  logic [11:0]      fill_data;
  logic             ram_we;
  logic [AddrW-1:0] ram_waddr;
  logic [11:0]      ram_wdata;

  assign wr_in_range = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
  assign wr_addr     = cell_addr({2'b00, wr_y}, {2'b00, wr_x});
  assign host_we     = wr_valid && wr_ready && wr_in_range;
  assign ram_we      = fill_we || host_we;
  assign ram_waddr   = fill_we ? fill_addr : wr_addr;
  assign ram_wdata   = fill_we ? fill_data : wr_color;

`ifdef FB_CLEAR_ENGINE_EN
  typedef enum logic [0:0] {StIdle, StClear} fill_state_e;

  fill_state_e      state_q, state_d;
  logic [AddrW-1:0] fill_cnt_q, fill_cnt_d;
  logic [11:0]      fill_color_q, fill_color_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      fill_cnt_q   <= '0;
      fill_color_q <= '0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_color_q <= fill_color_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    fill_color_d = fill_color_q;
    fill_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d      = StClear;
          fill_cnt_d   = '0;
          fill_color_d = clear_color;
        end
      end
      StClear: begin
        // clear_req is deliberately not looked at here, so a sweep never restarts.
        fill_we = 1'b1;
        if (fill_cnt_q == AddrW'(Depth - 1)) begin
          state_d    = StIdle;
          fill_cnt_d = '0;
        end else begin
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign fill_addr  = fill_cnt_q;
  assign fill_data  = fill_color_q;
  assign clear_busy = (state_q == StClear);
  assign wr_ready   = (state_q == StIdle);
`else
  logic unused_clear;

  assign unused_clear = ^{clear_req, clear_color};
  assign fill_we      = 1'b0;
  assign fill_addr    = '0;
  assign fill_data    = '0;
  assign clear_busy   = 1'b0;
  assign wr_ready     = 1'b1;
`endif

  // Storage: not reset; read-first since the read samples the pre-write contents.
  logic [11:0] mem_q [Depth];
  logic [11:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_waddr] <= ram_wdata;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  // Blank flag travels with the RAM read; output register is the second stage.
  logic        blank_q;
  logic [11:0] pix_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q <= 1'b1;
      pix_q   <= '0;
    end else begin
      blank_q <= rd_blank;
      pix_q   <= blank_q ? 12'h000 : rd_data_q;
    end
  end

  assign out_r = pix_q[11:8];
  assign out_g = pix_q[7:4];
  assign out_b = pix_q[3:0];

endmodule
